// File: rtl/tube_pkg.sv
// Shared definitions for the tube_scan 7-segment display controller.
// Holds register addresses, FSM state encoding, digit register layout and idle pin values.
package tube_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 6;
  localparam int unsigned ADDR_W     = 3;

  localparam logic [ADDR_W-1:0] ADDR_DIGIT0 = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT1 = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT2 = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT3 = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_DIV    = 3'd5;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] TUBE_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Per-digit register: {blank, dp, hex}
  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } digit_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex -> active-low 7-segment decoder with decimal point and blanking.
// Ports: hex (4-bit value), dp (decimal point on), blank (all segments off),
//        seg_c {dp,g,f,e,d,c,b,a} active-low.
module seg7_decode (
  input  logic [3:0] hex,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_c
);

  logic [6:0] glyph;

  // Segment patterns {g,f,e,d,c,b,a}, low = lit
  always_comb begin
    glyph = 7'h7F;
    case (hex)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  assign seg_c = blank ? 8'hFF : {~dp, glyph};

endmodule

// File: rtl/tube_scan.sv
// Avalon-MM slave that scans four hex digits onto a common-anode 4-digit 7-segment display,
// with an all-off gap between digits to suppress ghosting.
// Ports: clk, reset (sync, active-high); Avalon address/chipselect/write_n/writedata,
//        readdata (combinational, zero wait); seg_out {dp,g..a} and tube_en, both active-low
//        and registered.
module tube_scan
  import tube_pkg::*;
#(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned DEFAULT_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [7:0]        seg_out,
  output logic [3:0]        tube_en
);

  // Counter covers both the SHOW divider and the GAP length
  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned CNT_W   = (DIV_W > BLANK_W) ? DIV_W : BLANK_W;

  digit_t            digit_q [NUM_DIGITS];
  logic              ctrl_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_eff;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        dec_seg_c;
  logic              wr_en;
  logic              unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata[31:DIV_W];
  assign div_eff      = (div_q == '0) ? DIV_W'(1) : div_q;

  // Register file writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) digit_q[k] <= '0;
      ctrl_q <= 1'b0;
      div_q  <= DIV_W'(DEFAULT_DIV);
    end else if (wr_en) begin
      case (address)
        ADDR_DIGIT0: digit_q[0] <= digit_t'(writedata[DIGIT_W-1:0]);
        ADDR_DIGIT1: digit_q[1] <= digit_t'(writedata[DIGIT_W-1:0]);
        ADDR_DIGIT2: digit_q[2] <= digit_t'(writedata[DIGIT_W-1:0]);
        ADDR_DIGIT3: digit_q[3] <= digit_t'(writedata[DIGIT_W-1:0]);
        ADDR_CTRL:   ctrl_q     <= writedata[0];
        ADDR_DIV:    div_q      <= writedata[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  // Zero-wait read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DIGIT0: readdata = 32'(digit_q[0]);
      ADDR_DIGIT1: readdata = 32'(digit_q[1]);
      ADDR_DIGIT2: readdata = 32'(digit_q[2]);
      ADDR_DIGIT3: readdata = 32'(digit_q[3]);
      ADDR_CTRL:   readdata = 32'(ctrl_q);
      ADDR_DIV:    readdata = 32'(div_q);
      default:     readdata = '0;
    endcase
  end

  // Scan FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan FSM next state; a cleared enable wins from any state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!ctrl_q) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          // >= so that lowering DIV mid-phase ends the phase immediately
          if (cnt_q >= CNT_W'(div_eff) - CNT_W'(1)) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q >= CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_SHOW;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  seg7_decode u_dec (
    .hex   (digit_q[idx_d].hex),
    .dp    (digit_q[idx_d].dp),
    .blank (digit_q[idx_d].blank),
    .seg_c (dec_seg_c)
  );

  // Pin registers follow the next state so they line up with the FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      tube_en <= TUBE_OFF;
      seg_out <= SEG_OFF;
    end else if (state_d == ST_SHOW) begin
      tube_en <= ~(4'b0001 << idx_d);
      seg_out <= dec_seg_c;
    end else begin
      tube_en <= TUBE_OFF;
      seg_out <= SEG_OFF;
    end
  end

endmodule
